// File: rtl/crossbar_pkg.sv
// crossbar_pkg
//   Shared types and helpers for the crossbar allocator.
//   - in_state_t : per-input state (IDLE / PEND).
//   - DROP_CNT_W : width of the dropped-flit counter.
//   - rr_pick()  : round-robin search returning winner index and a found bit.
//   Optional feature macro used by the top: CROSSBAR_ALLOC_STATS_EN.
package crossbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } in_state_t;

    localparam int DROP_CNT_W = 16;

    // rr_pick works on a fixed-width request vector; PORTS must not exceed MAX_PORTS.
    localparam int MAX_PORTS = 32;
    localparam int MAX_IDX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of mask at or after ptr, searching upward and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] mask,
                                         input int unsigned          ptr,
                                         input int unsigned          n);
        rr_pick_t    r;
        int unsigned c;
        r = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            c = ptr + k;
            if (c >= n) c = c - n;
            if (k < n && !r.found && mask[c[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter for one crossbar output. The pointer only moves when a
//   grant is actually taken, so a stalled output keeps presenting the same winner.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//     req_i      : request per input
//     advance_i  : output accepted the granted flit this cycle
//     grant_o    : one-hot grant
//     found_o    : some input is requesting
//     idx_o      : index of the granted input
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req_i,
    input  logic             advance_i,
    output logic [PORTS-1:0] grant_o,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    rr_pick_t         pick;
    logic             unused_idx_bits;

    assign unused_idx_bits = ^pick.idx;

    always_comb begin
        pick    = rr_pick(MAX_PORTS'(req_i), 32'(ptr_q), PORTS);
        found_o = pick.found;
        idx_o   = pick.idx[IDX_W-1:0];
        grant_o = '0;
        if (pick.found) grant_o[idx_o] = 1'b1;

        // Winner + 1 with wrap; PORTS need not be a power of two.
        ptr_d = ptr_q;
        if (advance_i && pick.found)
            ptr_d = (idx_o == IDX_W'(PORTS - 1)) ? '0 : idx_o + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    a_onehot : assert property (@(posedge clk) disable iff (rst)
        found_o |-> $onehot(grant_o));

endmodule

// File: rtl/crossbar_alloc.sv
// crossbar_alloc
//   Multicast PORTS x PORTS crossbar allocator. Each input offers one flit with
//   a destination mask; each output picks round-robin among requesting inputs.
//   A multicast that is only partly served parks its leftover bits in pend_q
//   until every requested output has taken the flit. Data passes straight
//   through (no register in the data path).
//   Optional feature: define CROSSBAR_ALLOC_STATS_EN to add drop_cnt, a
//   saturating count of zero-destination flits consumed.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     in_valid    : input i holds a flit
//     in_dest     : flat, bits [i*PORTS +: PORTS] = destination mask of input i
//     in_data     : flat, bits [i*WIDTH +: WIDTH] = flit of input i
//     in_ready    : input i fully delivered this cycle
//     out_valid   : output j carries a flit
//     out_data    : flat, bits [j*WIDTH +: WIDTH]; zero when out_valid[j]=0
//     out_ready   : output j accepts its flit
//     drop_cnt    : zero-mask flits discarded (stats build only)
module crossbar_alloc
    import crossbar_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       in_valid,
    input  logic [PORTS*PORTS-1:0] in_dest,
    input  logic [PORTS*WIDTH-1:0] in_data,
    output logic [PORTS-1:0]       in_ready,
    output logic [PORTS-1:0]       out_valid,
    output logic [PORTS*WIDTH-1:0] out_data,
    input  logic [PORTS-1:0]       out_ready
`ifdef CROSSBAR_ALLOC_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    in_state_t        state_q [PORTS];
    in_state_t        state_d [PORTS];
    logic [PORTS-1:0] pend_q  [PORTS];
    logic [PORTS-1:0] pend_d  [PORTS];
    logic [PORTS-1:0] eff     [PORTS];  // [input] bit = output
    logic [PORTS-1:0] req     [PORTS];  // [output] bit = input
    logic [PORTS-1:0] gnt     [PORTS];  // [output] bit = input
    logic [PORTS-1:0] dlv     [PORTS];  // [input] bit = output
    logic [IDX_W-1:0] idx     [PORTS];
    logic [PORTS-1:0] found;

    // Effective mask and per-output request vectors (transpose of eff).
    always_comb begin
        for (int i = 0; i < PORTS; i++)
            eff[i] = (state_q[i] == PEND) ? pend_q[i] : in_dest[i*PORTS +: PORTS];
        for (int j = 0; j < PORTS; j++) begin
            req[j] = '0;
            for (int i = 0; i < PORTS; i++)
                req[j][i] = in_valid[i] & eff[i][j];
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_out
        rr_arbiter #(.PORTS(PORTS), .IDX_W(IDX_W)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req_i     (req[j]),
            .advance_i (out_ready[j]),
            .grant_o   (gnt[j]),
            .found_o   (found[j]),
            .idx_o     (idx[j])
        );
    end

    // Outputs and delivery matrix. Outputs are forced quiet while rst is high
    // since they are combinational from the inputs.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < PORTS; j++) begin
            out_valid[j] = found[j] & ~rst;
            if (found[j] && !rst)
                out_data[j*WIDTH +: WIDTH] = in_data[int'(idx[j])*WIDTH +: WIDTH];
        end
        for (int i = 0; i < PORTS; i++) begin
            dlv[i] = '0;
            for (int j = 0; j < PORTS; j++)
                dlv[i][j] = gnt[j][i] & out_ready[j];
            // Zero effective mask falls out here as an immediate consume (drop).
            in_ready[i] = in_valid[i] & ~rst & ((eff[i] & ~dlv[i]) == '0);
        end
    end

    // Per-input next state.
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
            case (state_q[i])
                IDLE: if (in_valid[i] && (dlv[i] != '0) && !in_ready[i]) begin
                    state_d[i] = PEND;
                    pend_d[i]  = eff[i] & ~dlv[i];
                end
                PEND: if (in_ready[i]) begin
                    state_d[i] = IDLE;
                    pend_d[i]  = '0;
                end else begin
                    pend_d[i]  = pend_q[i] & ~dlv[i];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                pend_q[i]  <= '0;
            end else begin
                state_q[i] <= state_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

`ifdef CROSSBAR_ALLOC_STATS_EN
    localparam int CW = DROP_CNT_W + 1;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [CW-1:0]         drop_sum;

    // One extra bit catches the carry; on carry the counter pins at all-ones.
    always_comb begin
        drop_sum = {1'b0, drop_q};
        for (int i = 0; i < PORTS; i++)
            if (in_ready[i] && state_q[i] == IDLE && eff[i] == '0)
                drop_sum = drop_sum + CW'(1);
        drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

    for (genvar i = 0; i < PORTS; i++) begin : g_chk
        a_pend_valid : assert property (@(posedge clk) disable iff (rst)
            (state_q[i] == PEND) |-> in_valid[i]);
    end

endmodule

// File: tb/tb_crossbar_alloc.sv
module tb_crossbar_alloc;
    localparam int P = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   in_valid;
    logic [P*P-1:0] in_dest;
    logic [P*W-1:0] in_data;
    logic [P-1:0]   in_ready;
    logic [P-1:0]   out_valid;
    logic [P*W-1:0] out_data;
    logic [P-1:0]   out_ready;
`ifdef CROSSBAR_ALLOC_STATS_EN
    logic [15:0]    drop_cnt;
`endif

    crossbar_alloc #(.PORTS(P), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef CROSSBAR_ALLOC_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    ev_t oq [P][$];  // expected presentations per output (cycle, data)
    ev_t iq [P][$];  // expected consumes per input (cycle, data)
    int  errors = 0;
    int  checks = 0;

    task automatic set_in(input int i, input logic v, input logic [3:0] dst, input logic [7:0] d);
        in_valid[i]       = v;
        in_dest[i*P +: P] = dst;
        in_data[i*W +: W] = d;
    endtask

    task automatic exp_out(input int j, input int c, input logic [7:0] d);
        oq[j].push_back('{c, d});
    endtask

    task automatic exp_in(input int i, input int c, input logic [7:0] d);
        iq[i].push_back('{c, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents something.
    always @(negedge clk) begin : mon
        ev_t e;
        for (int j = 0; j < P; j++) begin
            checks++;
            if (out_valid[j]) begin
                if (oq[j].size() == 0) begin
                    errors++;
                    $display("FAIL out%0d_unexpected cyc=%0d got data=%h required no valid", j, cyc, out_data[j*W +: W]);
                end else begin
                    e = oq[j].pop_front();
                    if (e.c != cyc || e.d != out_data[j*W +: W]) begin
                        errors++;
                        $display("FAIL out%0d cyc=%0d data=%h required cyc=%0d data=%h", j, cyc, out_data[j*W +: W], e.c, e.d);
                    end
                end
            end else if (out_data[j*W +: W] != 8'h00) begin
                errors++;
                $display("FAIL out%0d_idle_data cyc=%0d got %h required 00", j, cyc, out_data[j*W +: W]);
            end
        end
        for (int i = 0; i < P; i++) begin
            if (in_ready[i]) begin
                checks++;
                if (iq[i].size() == 0) begin
                    errors++;
                    $display("FAIL in%0d_ready_unexpected cyc=%0d got 1 required 0", i, cyc);
                end else begin
                    e = iq[i].pop_front();
                    if (e.c != cyc || e.d != in_data[i*W +: W]) begin
                        errors++;
                        $display("FAIL in%0d_ready cyc=%0d data=%h required cyc=%0d data=%h", i, cyc, in_data[i*W +: W], e.c, e.d);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_dest   = '0;
        in_data   = '0;
        out_ready = '1;
        step();
        // Traffic during reset must stay invisible.
        set_in(0, 1'b1, 4'b0001, 8'hEE);
        step();
        step();
        set_in(0, 1'b0, 4'b0000, 8'h00);
        rst = 1'b0;
        step();

        // Unicast, no contention.
        set_in(0, 1'b1, 4'b0010, 8'hA5);
        exp_out(1, cyc, 8'hA5); exp_in(0, cyc, 8'hA5);
        step();
        set_in(0, 1'b0, 4'b0000, 8'h00);
        step();

        // Round-robin on output 0 between in0 and in2.
        set_in(0, 1'b1, 4'b0001, 8'h10); set_in(2, 1'b1, 4'b0001, 8'h20);
        exp_out(0, cyc, 8'h10); exp_in(0, cyc, 8'h10);
        step();
        set_in(0, 1'b1, 4'b0001, 8'h11);
        exp_out(0, cyc, 8'h20); exp_in(2, cyc, 8'h20);
        step();
        set_in(2, 1'b1, 4'b0001, 8'h21);
        exp_out(0, cyc, 8'h11); exp_in(0, cyc, 8'h11);
        step();
        set_in(0, 1'b1, 4'b0001, 8'h12);
        exp_out(0, cyc, 8'h21); exp_in(2, cyc, 8'h21);
        step();
        set_in(0, 1'b0, 4'b0000, 8'h00); set_in(2, 1'b0, 4'b0000, 8'h00);
        step();

        // Partial multicast: in0 wins output 0, in1 gets 1 and 3 now, 0 next.
        set_in(0, 1'b1, 4'b0001, 8'h0A); set_in(1, 1'b1, 4'b1011, 8'h0B);
        exp_out(0, cyc, 8'h0A); exp_out(1, cyc, 8'h0B); exp_out(3, cyc, 8'h0B);
        exp_in(0, cyc, 8'h0A);
        step();
        set_in(0, 1'b0, 4'b0000, 8'h00);
        exp_out(0, cyc, 8'h0B); exp_in(1, cyc, 8'h0B);
        step();
        set_in(1, 1'b0, 4'b0000, 8'h00);
        step();

        // Backpressure on output 2 for three cycles.
        out_ready[2] = 1'b0;
        set_in(3, 1'b1, 4'b0100, 8'hC3);
        for (int k = 0; k < 3; k++) begin
            exp_out(2, cyc, 8'hC3);
            step();
        end
        out_ready[2] = 1'b1;
        exp_out(2, cyc, 8'hC3); exp_in(3, cyc, 8'hC3);
        step();
        set_in(3, 1'b0, 4'b0000, 8'h00);
        step();

        // Zero-mask drops.
        set_in(2, 1'b1, 4'b0000, 8'h77);
        exp_in(2, cyc, 8'h77);
        step();
`ifdef CROSSBAR_ALLOC_STATS_EN
        checks++;
        if (drop_cnt != 16'd1) begin
            errors++;
            $display("FAIL drop_cnt_one got %0d required 1", drop_cnt);
        end
`endif
        set_in(2, 1'b0, 4'b0000, 8'h00);
        set_in(0, 1'b1, 4'b0000, 8'h55); set_in(1, 1'b1, 4'b0000, 8'h66);
        exp_in(0, cyc, 8'h55); exp_in(1, cyc, 8'h66);
        step();
`ifdef CROSSBAR_ALLOC_STATS_EN
        checks++;
        if (drop_cnt != 16'd3) begin
            errors++;
            $display("FAIL drop_cnt_three got %0d required 3", drop_cnt);
        end
`endif
        set_in(0, 1'b0, 4'b0000, 8'h00); set_in(1, 1'b0, 4'b0000, 8'h00);
        step();

        // Reset while in1 is pending; full mask must be served again after.
        set_in(0, 1'b1, 4'b0001, 8'h01); set_in(1, 1'b1, 4'b0011, 8'h5E);
        exp_out(0, cyc, 8'h01); exp_out(1, cyc, 8'h5E); exp_in(0, cyc, 8'h01);
        step();
        set_in(0, 1'b0, 4'b0000, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef CROSSBAR_ALLOC_STATS_EN
        checks++;
        if (drop_cnt != 16'd0) begin
            errors++;
            $display("FAIL drop_cnt_reset got %0d required 0", drop_cnt);
        end
`endif
        exp_out(0, cyc, 8'h5E); exp_out(1, cyc, 8'h5E); exp_in(1, cyc, 8'h5E);
        step();
        set_in(1, 1'b0, 4'b0000, 8'h00);
        step();
        step();

        // Every expectation must have been consumed.
        for (int j = 0; j < P; j++) begin
            checks++;
            if (oq[j].size() != 0) begin
                errors++;
                $display("FAIL out%0d_missing got %0d pending required 0", j, oq[j].size());
            end
            checks++;
            if (iq[j].size() != 0) begin
                errors++;
                $display("FAIL in%0d_missing got %0d pending required 0", j, iq[j].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
